// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - host driver for the switch-box serial configuration chain
// Serializes host words MSB-first into the chain head and returns the bits leaving the tail as readback words.
module config_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 256,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              cfg_en,
  output logic              cfg_data_out,
  input  logic              cfg_data_in,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  input  logic              rb_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_shifted
);

  localparam int NW   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int R    = CHAIN_LEN - (NW - 1) * WORD_W;
  localparam int NB_W = $clog2(WORD_W + 1);
  localparam logic [NB_W-1:0] NB_FULL = NB_W'(WORD_W);
  localparam logic [NB_W-1:0] NB_LAST = NB_W'(R);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_RB_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] tx_sr_q, tx_sr_d;
  logic [WORD_W-1:0] rb_sr_q, rb_sr_d;
  logic [NB_W-1:0]   nbits_q, nbits_d;
  logic [NB_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  bits_shifted_q, bits_shifted_d;
  logic              last_word;
  logic [WORD_W-1:0] rb_mask;

  assign last_word = (word_cnt_q == LAST_WORD);

  always_comb begin
    state_d        = state_q;
    tx_sr_d        = tx_sr_q;
    rb_sr_d        = rb_sr_q;
    nbits_d        = nbits_q;
    bit_cnt_d      = bit_cnt_q;
    word_cnt_d     = word_cnt_q;
    bits_shifted_d = bits_shifted_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d        = S_LOAD;
            bits_shifted_d = '0;
            word_cnt_d     = '0;
            rb_sr_d        = '0;
          end
        end
        S_LOAD: begin
          if (word_valid) begin
            // A short final word is left-justified so its MSB leaves first like a full word.
            tx_sr_d   = last_word ? (word_data << (WORD_W - R)) : word_data;
            nbits_d   = last_word ? NB_LAST : NB_FULL;
            bit_cnt_d = '0;
            state_d   = S_SHIFT;
          end
        end
        S_SHIFT: begin
          tx_sr_d        = {tx_sr_q[WORD_W-2:0], 1'b0};
          rb_sr_d        = {rb_sr_q[WORD_W-2:0], cfg_data_in};
          bits_shifted_d = bits_shifted_q + CNT_W'(1);
          bit_cnt_d      = bit_cnt_q + NB_W'(1);
          if ((bit_cnt_q + NB_W'(1)) == nbits_q) begin
            state_d = S_RB_WAIT;
          end
        end
        S_RB_WAIT: begin
          if (rb_ready) begin
            rb_sr_d    = '0;
            word_cnt_d = word_cnt_q + CNT_W'(1);
            state_d    = last_word ? S_DONE : S_LOAD;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= S_IDLE;
      tx_sr_q        <= '0;
      rb_sr_q        <= '0;
      nbits_q        <= '0;
      bit_cnt_q      <= '0;
      word_cnt_q     <= '0;
      bits_shifted_q <= '0;
    end else begin
      state_q        <= state_d;
      tx_sr_q        <= tx_sr_d;
      rb_sr_q        <= rb_sr_d;
      nbits_q        <= nbits_d;
      bit_cnt_q      <= bit_cnt_d;
      word_cnt_q     <= word_cnt_d;
      bits_shifted_q <= bits_shifted_d;
    end
  end

  // Only the bits actually shifted for this word are reported; stale upper bits are hidden.
  always_comb begin
    rb_mask = '0;
    for (int i = 0; i < WORD_W; i++) begin
      rb_mask[i] = (NB_W'(i) < nbits_q);
    end
  end

  assign word_ready   = (state_q == S_LOAD);
  assign cfg_en       = (state_q == S_SHIFT);
  assign cfg_data_out = cfg_en & tx_sr_q[WORD_W-1];
  assign rb_valid     = (state_q == S_RB_WAIT);
  assign rb_data      = rb_valid ? (rb_sr_q & rb_mask) : '0;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign bits_shifted = bits_shifted_q;

endmodule
